ram_responder: RTL and testbench
================================

# ram_responder

Data-RAM responder for the simple CPU's RAM port. It accepts the CPU's enable, write-enable, read-enable, address and write-data, stores words in an internal array, and returns read data with a fixed one-cycle latency. An optional post-reset clear sequencer sweeps the array to a known value before the first access is accepted. It sits between the CPU core and the data-memory array at top level.

## Interface
- g_RAM_WIDTH, 11, data word width in bits
- g_RAM_ADDR, 9, address width in bits
- g_RAM_DEPTH, 512, number of implemented words (≤ 2^g_RAM_ADDR)
- g_CLEAR_VALUE, 0, word written to every location by the clear sequencer

- i_clk  in  1  single clock; all logic on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_ram_en  in  1  request qualifier; nothing happens when low
- i_ram_we  in  1  write strobe (qualified by i_ram_en)
- i_ram_re  in  1  read strobe (qualified by i_ram_en)
- i_ram_addr  in  g_RAM_ADDR  word address
- i_ram_data  in  g_RAM_WIDTH  write data
- o_ram_data  out  g_RAM_WIDTH  registered read data
- o_ram_rvalid  out  1  one-cycle pulse: o_ram_data is fresh
- o_ram_err  out  1  one-cycle pulse: previous request rejected or out of range
- o_ram_busy  out  1  high while clear sequence runs; requests are not accepted

## Operation
- FSM states: RS_CLEAR, RS_READY. Reset enters RS_CLEAR (macro defined) or RS_READY (macro undefined).
- RS_CLEAR: 9-bit-wide (g_RAM_ADDR) counter starts at 0, writes g_CLEAR_VALUE to one word per cycle, increments; after writing word g_RAM_DEPTH-1, moves to RS_READY. Counter does not wrap.
- RS_READY: request = i_ram_en & (i_ram_we | i_ram_re).
  - Write: array[addr] <= i_ram_data at the edge.
  - Read: o_ram_data <= array[addr]; o_ram_rvalid = 1 next cycle.
  - we and re together, same address: read-first; read returns old contents, write takes effect.
  - addr ≥ g_RAM_DEPTH: write dropped; read returns 0 with o_ram_rvalid = 1; o_ram_err = 1 in the same cycle.
- Request while o_ram_busy = 1: ignored (no write, no rvalid); o_ram_err = 1 next cycle.
- i_ram_en = 0 or no strobe: no array change; o_ram_data holds last value; rvalid/err = 0.

## Timing
- Reset values: o_ram_data = 0, o_ram_rvalid = 0, o_ram_err = 0, o_ram_busy = 1 (macro defined) / 0 (undefined); clear counter = 0.
- Read latency: exactly 1 cycle, request at edge N, data and rvalid valid after edge N+1 until edge N+2.
- Back-to-back reads/writes every cycle supported; no ready/stall.
- Write at edge N, read of same address at edge N+1 returns new data.
- Clear duration: o_ram_busy high for exactly g_RAM_DEPTH cycles after first rising edge with i_rst_n = 1; drops registered, first accepted request on the following edge.
- Reset asserted mid-clear or mid-read: outputs return to reset values immediately; clear restarts at address 0 on release.

## Configuration
- RAM_RESPONDER_CLEAR_EN defined: RS_CLEAR state, counter and busy logic compiled in; array contents deterministic after clear.
- Undefined: FSM reduced to RS_READY; o_ram_busy tied 0; array contents undefined after reset (X in simulation); reads accepted on the first edge after reset release.

## Structure
- Package ram_pkg: state encoding (RS_CLEAR, RS_READY), width/depth defaults shared with the CPU's g_RAM_WIDTH/g_RAM_ADDR.
- Sub-module ram_array: single-port synchronous array, read-first, one write/read port; ram_responder holds FSM, counter, range check, muxing of clear vs CPU port, and output registers.

## Test plan
- Macro defined, release reset, hold i_ram_en = 1, re = 1, addr 5 -> o_ram_busy high 512 cycles, err pulses each ignored cycle, then first read returns 0x000 with rvalid.
- Write 0x7FF to addr 10, read addr 10 next cycle -> o_ram_data = 0x7FF, rvalid one cycle after the read.
- Addr 10 holds 0x123; we = re = 1, data 0x456 -> read returns 0x123; subsequent read returns 0x456.
- g_RAM_DEPTH = 256, read addr 300 -> o_ram_data = 0, rvalid = 1, err = 1; write to 300 leaves addr 44 unchanged.
- Assert i_rst_n = 0 at clear count 100, release -> busy high for full 512 cycles again; words 0..511 read back g_CLEAR_VALUE.
- Macro undefined -> o_ram_busy = 0 from reset; write/read addr 0 on first two edges -> correct data, no err.

Source files
------------

// File: rtl/ram_pkg.sv
// ============================================================================
// ram_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the CPU data-RAM responder: the responder state
// encoding, the width/depth defaults that match the CPU's g_RAM_WIDTH and
// g_RAM_ADDR, and a range-check helper used when decoding requests.
// No ports (package).
// ============================================================================
package ram_pkg;

    localparam int unsigned RAM_WIDTH_DEFAULT = 11;
    localparam int unsigned RAM_ADDR_DEFAULT  = 9;
    localparam int unsigned RAM_DEPTH_DEFAULT = 512;

    typedef enum logic {
        RS_CLEAR = 1'b0,
        RS_READY = 1'b1
    } ram_state_e;

    // The address is widened to 32 bits before comparing so the check stays
    // meaningful even when the depth fills the whole address space.
    function automatic logic addrInRange(input logic [31:0] addr,
                                         input int unsigned depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/ram_array.sv
// ============================================================================
// ram_array
// ----------------------------------------------------------------------------
// Single-port synchronous word array with one shared read/write port.
// Read-first: a read and write to the same word at the same edge returns the
// old contents while the new word is stored. Read data is registered and only
// updates on a read, so it holds its last value between reads.
// Contents are not reset.
//
// Ports:
//   clk_i    : clock, rising edge
//   we_i     : write enable
//   re_i     : read enable
//   addr_i   : word address (must be < g_DEPTH when we_i/re_i are high)
//   wdata_i  : write data
//   rdata_o  : registered read data
// ============================================================================
module ram_array #(
    parameter int unsigned g_WIDTH = 11,
    parameter int unsigned g_ADDR  = 9,
    parameter int unsigned g_DEPTH = 512
) (
    input  logic               clk_i,
    input  logic               we_i,
    input  logic               re_i,
    input  logic [g_ADDR-1:0]  addr_i,
    input  logic [g_WIDTH-1:0] wdata_i,
    output logic [g_WIDTH-1:0] rdata_o
);

    localparam int unsigned IDX_W = (g_DEPTH > 1) ? $clog2(g_DEPTH) : 1;

    logic [g_WIDTH-1:0] mem_q [g_DEPTH];
    logic [g_WIDTH-1:0] rdata_q;
    logic [IDX_W-1:0]   idx;

    // Only the low address bits index the array; the caller guarantees the
    // address is in range whenever a strobe is asserted.
    assign idx = addr_i[IDX_W-1:0];

    // Storage and read register. The read samples the array before the
    // write lands, which gives read-first behaviour on a shared address.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[idx];
        end
        if (we_i) begin
            mem_q[idx] <= wdata_i;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_responder.sv
// ============================================================================
// ram_responder
// ----------------------------------------------------------------------------
// Data-RAM responder for the simple CPU's RAM port. Accepts enable, write and
// read strobes, address and write data; stores words in ram_array and returns
// read data one cycle after the request. Out-of-range reads return zero with
// rvalid and err; out-of-range writes are dropped with err.
//
// Optional feature (macro RAM_RESPONDER_CLEAR_EN): after reset a clear
// sequencer writes g_CLEAR_VALUE to every word, one per cycle, holding
// o_ram_busy high and rejecting requests (err pulse) until it finishes.
// Without the macro the responder is ready on the first edge after reset and
// the array contents are undefined.
//
// Ports:
//   i_clk        : clock, rising edge
//   i_rst_n      : asynchronous active-low reset
//   i_ram_en     : request qualifier
//   i_ram_we     : write strobe
//   i_ram_re     : read strobe
//   i_ram_addr   : word address
//   i_ram_data   : write data
//   o_ram_data   : registered read data (holds between reads)
//   o_ram_rvalid : one-cycle pulse, o_ram_data is fresh
//   o_ram_err    : one-cycle pulse, previous request rejected or out of range
//   o_ram_busy   : clear sequence running, requests not accepted
// ============================================================================
module ram_responder
    import ram_pkg::*;
#(
    parameter int unsigned            g_RAM_WIDTH   = RAM_WIDTH_DEFAULT,
    parameter int unsigned            g_RAM_ADDR    = RAM_ADDR_DEFAULT,
    parameter int unsigned            g_RAM_DEPTH   = RAM_DEPTH_DEFAULT,
    parameter logic [g_RAM_WIDTH-1:0] g_CLEAR_VALUE = '0
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_ram_en,
    input  logic                   i_ram_we,
    input  logic                   i_ram_re,
    input  logic [g_RAM_ADDR-1:0]  i_ram_addr,
    input  logic [g_RAM_WIDTH-1:0] i_ram_data,
    output logic [g_RAM_WIDTH-1:0] o_ram_data,
    output logic                   o_ram_rvalid,
    output logic                   o_ram_err,
    output logic                   o_ram_busy
);

    logic                   req;
    logic                   inRange;
    logic                   busy;
    logic                   arrWe;
    logic                   arrRe;
    logic [g_RAM_ADDR-1:0]  arrAddr;
    logic [g_RAM_WIDTH-1:0] arrWdata;
    logic [g_RAM_WIDTH-1:0] arrRdata;
    logic                   rvalid_q, rvalid_d;
    logic                   err_q, err_d;
    logic                   zeroSel_q, zeroSel_d;

    assign req     = i_ram_en & (i_ram_we | i_ram_re);
    assign inRange = addrInRange(32'(i_ram_addr), g_RAM_DEPTH);

`ifdef RAM_RESPONDER_CLEAR_EN
    ram_state_e            state_q, state_d;
    logic [g_RAM_ADDR-1:0] clrCnt_q, clrCnt_d;

    // Clear sequencer state and sweep counter. Reset always restarts the
    // sweep from word 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= RS_CLEAR;
            clrCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            clrCnt_q <= clrCnt_d;
        end
    end

    assign busy = (state_q == RS_CLEAR);
`else
    // The clear value only matters when the sequencer is built in.
    logic [g_RAM_WIDTH-1:0] unusedClearValue;
    assign unusedClearValue = g_CLEAR_VALUE;
    assign busy             = 1'b0;
`endif

    // Array port arbitration and next-state logic. The CPU owns the port
    // unless the clear sweep is running, in which case the sweep writes one
    // word per cycle and stops after the last implemented word without
    // wrapping the counter. Out-of-range and busy requests never reach the
    // array; a zero-select flag stands in for the read data of an
    // out-of-range read.
    always_comb begin
        arrAddr   = i_ram_addr;
        arrWdata  = i_ram_data;
        arrWe     = i_ram_en & i_ram_we & inRange & ~busy;
        arrRe     = i_ram_en & i_ram_re & inRange & ~busy;
        rvalid_d  = i_ram_en & i_ram_re & ~busy;
        err_d     = req & (busy | ~inRange);
        zeroSel_d = rvalid_d ? ~inRange : zeroSel_q;
`ifdef RAM_RESPONDER_CLEAR_EN
        state_d   = state_q;
        clrCnt_d  = clrCnt_q;
        if (state_q == RS_CLEAR) begin
            arrWe    = 1'b1;
            arrAddr  = clrCnt_q;
            arrWdata = g_CLEAR_VALUE;
            if (32'(clrCnt_q) == (g_RAM_DEPTH - 1)) begin
                state_d = RS_READY;
            end else begin
                clrCnt_d = clrCnt_q + g_RAM_ADDR'(1);
            end
        end
`endif
    end

    // Response registers. Reset selects the zero source so o_ram_data reads
    // 0 immediately, even though the array read register is not reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            zeroSel_q <= 1'b1;
        end else begin
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
            zeroSel_q <= zeroSel_d;
        end
    end

    ram_array #(
        .g_WIDTH (g_RAM_WIDTH),
        .g_ADDR  (g_RAM_ADDR),
        .g_DEPTH (g_RAM_DEPTH)
    ) u_array (
        .clk_i   (i_clk),
        .we_i    (arrWe),
        .re_i    (arrRe),
        .addr_i  (arrAddr),
        .wdata_i (arrWdata),
        .rdata_o (arrRdata)
    );

    assign o_ram_data   = zeroSel_q ? '0 : arrRdata;
    assign o_ram_rvalid = rvalid_q;
    assign o_ram_err    = err_q;
    assign o_ram_busy   = busy;

endmodule

// File: tb/tb_ram_responder.sv
// ============================================================================
// tb_ram_responder
// ----------------------------------------------------------------------------
// Randomized scoreboard bench for ram_responder. The stimulus side keeps a
// plain array model of memory and pushes the expected response of every
// request that should produce rvalid or err; a monitor pops and compares on
// each response pulse and checks busy and read-data hold every cycle.
// Honors RAM_RESPONDER_CLEAR_EN for the clear-sequencer scenarios.
// ============================================================================
module tb_ram_responder;

    localparam int W = 11;
    localparam int A = 9;
`ifdef RAM_RESPONDER_CLEAR_EN
    localparam int DEPTH    = 512;
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam int DEPTH    = 256;
    localparam bit CLEAR_EN = 1'b0;
`endif
    localparam logic [W-1:0] CLEARV = 11'h000;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         ramEn = 1'b0;
    logic         ramWe = 1'b0;
    logic         ramRe = 1'b0;
    logic [A-1:0] ramAddr  = '0;
    logic [W-1:0] ramWdata = '0;
    logic [W-1:0] ramRdata;
    logic         ramRvalid;
    logic         ramErr;
    logic         ramBusy;

    typedef struct {
        logic [W-1:0] data;
        bit           known;
        bit           rvalid;
        bit           err;
    } exp_t;

    exp_t         expQ[$];
    logic [W-1:0] model [2**A];
    bit           known [2**A];
    int           compared   = 0;
    int           mismatched = 0;
    int           edgeIdx    = 0;
    bit           expBusy    = 1'b0;
    bit           lastKnown  = 1'b1;
    logic [W-1:0] lastData   = '0;

    ram_responder #(
        .g_RAM_WIDTH   (W),
        .g_RAM_ADDR    (A),
        .g_RAM_DEPTH   (DEPTH),
        .g_CLEAR_VALUE (CLEARV)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_ram_en     (ramEn),
        .i_ram_we     (ramWe),
        .i_ram_re     (ramRe),
        .i_ram_addr   (ramAddr),
        .i_ram_data   (ramWdata),
        .o_ram_data   (ramRdata),
        .o_ram_rvalid (ramRvalid),
        .o_ram_err    (ramErr),
        .o_ram_busy   (ramBusy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            checkOutput("busy", 32'(ramBusy), 32'(expBusy));
            if (ramRvalid === 1'b1 || ramErr === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected response rvalid/err", {30'b0, ramRvalid, ramErr}, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("rvalid", 32'(ramRvalid), 32'(e.rvalid));
                    checkOutput("err", 32'(ramErr), 32'(e.err));
                    if (e.rvalid) begin
                        if (e.known) checkOutput("rdata", 32'(ramRdata), 32'(e.data));
                        lastKnown = e.known;
                        lastData  = e.data;
                    end else if (lastKnown) begin
                        checkOutput("rdata hold on err", 32'(ramRdata), 32'(lastData));
                    end
                end
            end else if (lastKnown) begin
                checkOutput("rdata hold", 32'(ramRdata), 32'(lastData));
            end
        end
    end

    // Issues one request (captured at the next rising edge) and records the
    // response the memory rules demand for it.
    task automatic applyStimulus(input logic en, input logic we, input logic re,
                                 input logic [A-1:0] addr, input logic [W-1:0] data);
        exp_t e;
        bit   busyCap;
        ramEn    = en;
        ramWe    = we;
        ramRe    = re;
        ramAddr  = addr;
        ramWdata = data;
        busyCap  = CLEAR_EN && (edgeIdx < DEPTH);
        if (en && (we || re)) begin
            if (busyCap) begin
                e = '{data: '0, known: 1'b0, rvalid: 1'b0, err: 1'b1};
                expQ.push_back(e);
            end else if (int'(addr) >= DEPTH) begin
                e = '{data: '0, known: 1'b1, rvalid: re, err: 1'b1};
                expQ.push_back(e);
            end else begin
                if (re) begin
                    e = '{data: model[addr], known: known[addr], rvalid: 1'b1, err: 1'b0};
                    expQ.push_back(e);
                end
                if (we) begin
                    model[addr] = data;
                    known[addr] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #2;
        edgeIdx++;
        if (CLEAR_EN && edgeIdx == DEPTH) begin
            for (int i = 0; i < DEPTH; i++) begin
                model[i] = CLEARV;
                known[i] = 1'b1;
            end
        end
        expBusy = CLEAR_EN && (edgeIdx < DEPTH);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        ramEn = 1'b0;
        ramWe = 1'b0;
        ramRe = 1'b0;
        expQ.delete();
        #1;
        checkOutput("reset rdata", 32'(ramRdata), 32'd0);
        checkOutput("reset rvalid", 32'(ramRvalid), 32'd0);
        checkOutput("reset err", 32'(ramErr), 32'd0);
        checkOutput("reset busy", 32'(ramBusy), 32'(CLEAR_EN));
        repeat (2) @(posedge clk);
        #2;
        for (int i = 0; i < 2**A; i++) known[i] = 1'b0;
        rst_n     = 1'b1;
        edgeIdx   = 0;
        expBusy   = CLEAR_EN;
        lastKnown = 1'b1;
        lastData  = '0;
    endtask

    initial begin
        logic [A-1:0] a;
        doReset();
`ifdef RAM_RESPONDER_CLEAR_EN
        repeat (100) applyStimulus(1'b1, 1'b0, 1'b1, 9'd5, '0);
        doReset();
        for (int k = 0; k < DEPTH + 1; k++) applyStimulus(1'b1, 1'b0, 1'b1, 9'd5, '0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 1'b1, A'(i), '0);
`else
        applyStimulus(1'b1, 1'b1, 1'b0, 9'd0, 11'h2AB);
        applyStimulus(1'b1, 1'b0, 1'b1, 9'd0, '0);
`endif
        applyStimulus(1'b1, 1'b1, 1'b0, 9'd10, 11'h7FF);
        applyStimulus(1'b1, 1'b0, 1'b1, 9'd10, '0);
        applyStimulus(1'b1, 1'b1, 1'b0, 9'd10, 11'h123);
        applyStimulus(1'b1, 1'b1, 1'b1, 9'd10, 11'h456);
        applyStimulus(1'b1, 1'b0, 1'b1, 9'd10, '0);
        applyStimulus(1'b0, 1'b1, 1'b1, 9'd10, 11'h001);
        applyStimulus(1'b1, 1'b0, 1'b1, 9'd10, '0);
`ifndef RAM_RESPONDER_CLEAR_EN
        applyStimulus(1'b1, 1'b1, 1'b0, 9'd44, 11'h0AA);
        applyStimulus(1'b1, 1'b1, 1'b0, 9'd300, 11'h1EE);
        applyStimulus(1'b1, 1'b0, 1'b1, 9'd300, '0);
        applyStimulus(1'b1, 1'b0, 1'b1, 9'd44, '0);
        applyStimulus(1'b1, 1'b1, 1'b1, 9'd511, 11'h3C3);
`endif
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 7) == 0) a = A'($urandom_range(0, 2**A - 1));
            else if ($urandom_range(0, 1) == 1) a = A'(248 + $urandom_range(0, 15));
            else a = A'($urandom_range(0, 15));
            applyStimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), a, W'($urandom_range(0, 2**W - 1)));
        end
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
